pcileech_perst_ctl: RTL
=======================

# pcileech_perst_ctl

PCIe PERST#/WAKE# conditioning stage between the board pins and the PCIe core/FIFO controller on the Artix-7 boards (NeTV2 first). It synchronises and glitch-filters the raw `pcie_perst_n` pin, sequences a stretched reset into `pcileech_pcie_a7`, and exposes a filtered PERST# level to `pcileech_fifo`. It also drives `pcie_wake_n` on request while the link is held in PERST#.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before the filtered PERST# level changes; legal range 1..65535.
- `RST_HOLD_CYCLES`, 100: cycles `pcie_rst` stays high after filtered PERST# deasserts; legal range 1..65535.
- `WAKE_PULSE_CYCLES`, 10000: maximum WAKE# low time per request; legal range 1..65535.

Ports:
- `clk`  in  1  100 MHz system clock; the block uses this one clock only.
- `rst`  in  1  reset, asynchronous, active-high.
- `pcie_perst_n_pin`  in  1  raw PERST# pin, asynchronous to `clk`.
- `wake_req`  in  1  single-cycle request to assert WAKE#.
- `pcie_perst_n_flt`  out  1  filtered PERST#, to the FIFO controller and PCIe core.
- `pcie_rst`  out  1  stretched reset to the PCIe core.
- `pcie_wake_n`  out  1  WAKE# pin, active-low.
- `wake_busy`  out  1  high while in S_WAKE.
- `perst_count`  out  16  number of filtered PERST# assertions, saturating.

## Operation
- Synchroniser: two flops. The output is `s`. Both flops reset to 0, so PERST# reads as asserted.
- Debounce:
  - 16-bit counter `cnt`, reset 0.
  - Each cycle `s != pcie_perst_n_flt`: if `cnt == DEBOUNCE_CYCLES-1`, then `pcie_perst_n_flt <= s` and `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - Each cycle `s == pcie_perst_n_flt`: `cnt <= 0`.
- FSM states: S_PERST (reset state), S_HOLD, S_RUN, S_WAKE.
  - S_PERST: `pcie_rst=1`.
    - Filtered rising edge → S_HOLD, with hold counter loaded to `RST_HOLD_CYCLES-1`.
    - Else `wake_req` → S_WAKE, with wake counter loaded to `WAKE_PULSE_CYCLES-1`.
  - S_HOLD: `pcie_rst=1`.
    - Filtered falling edge → S_PERST.
    - Else hold counter == 0 → S_RUN.
    - Else decrement the hold counter.
  - S_RUN: `pcie_rst=0`. Filtered falling edge → S_PERST.
  - S_WAKE: `pcie_rst=1`, `pcie_wake_n=0`.
    - Filtered rising edge → S_HOLD, and `pcie_wake_n` releases.
    - Else wake counter == 0 → S_PERST.
    - Else decrement the wake counter.
- `wake_req` is ignored in S_HOLD, S_RUN and S_WAKE. It is never queued.
- Simultaneous filtered rising edge and `wake_req` in S_PERST: the edge wins and the FSM goes to S_HOLD.
- `perst_count` increments on every filtered falling edge and saturates at 16'hFFFF. The reset-state level is not counted.
- All outputs are registered. `rst` returns every register to its reset value immediately, including mid-hold and mid-wake.

## Timing
- Reset values:
  - `pcie_perst_n_flt=0`
  - `pcie_rst=1`
  - `pcie_wake_n=1`
  - `wake_busy=0`
  - `perst_count=0`
  - FSM in S_PERST
- Pin edge to `s`: 2 clk edges. `s` change to `pcie_perst_n_flt` change: `DEBOUNCE_CYCLES` edges, provided `s` is stable.
- A glitch on `s` shorter than `DEBOUNCE_CYCLES` cycles produces no change on `pcie_perst_n_flt`.
- Filtered rise to `pcie_rst` fall: `RST_HOLD_CYCLES`+1 edges.
- Filtered fall to `pcie_rst` rise: 1 edge.
- `wake_req` sampled at edge N (in S_PERST): `pcie_wake_n` is low from edge N+1. If not pre-empted, it returns high at edge N+1+`WAKE_PULSE_CYCLES`.
- `wake_busy` mirrors `!pcie_wake_n` exactly.

## Configuration
- `PCILEECH_PERST_DEBOUNCE_EN` defined: debounce filter as above.
- Not defined: the counter is removed and `pcie_perst_n_flt <= s` every cycle, giving 3 edges from pin to filtered output. The `DEBOUNCE_CYCLES` parameter is accepted but unused. All other behaviour is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8`, `RST_HOLD_CYCLES=4`, `WAKE_PULSE_CYCLES=16`, with the macro defined unless stated.
- Power-up: hold pin=0, then release `rst` → `pcie_rst=1`, `pcie_perst_n_flt=0`, `pcie_wake_n=1`, `perst_count=0`.
- Clean release: pin 0→1 at edge 0 → `pcie_perst_n_flt` rises at edge 10; `pcie_rst` falls at edge 15. Re-assert pin → `perst_count=1`, and `pcie_rst=1` one edge after the filtered fall.
- Glitch: pin in S_RUN pulses low for 5 cycles → no change on `pcie_perst_n_flt`, `pcie_rst` or `perst_count`.
- Wake timeout: pin low, pulse `wake_req` at edge N → `pcie_wake_n` low over edges N+1..N+16 and high at N+17. A second `wake_req` during the pulse has no effect.
- Wake pre-empt and async reset:
  - Start a wake, then release pin → `pcie_wake_n` returns high on the filtered-rise edge and the FSM goes to S_HOLD.
  - Assert `rst` mid-S_HOLD → all outputs return to reset values without waiting for a clock edge.
- Macro undefined: pin 0→1 → `pcie_perst_n_flt` rises after 3 edges, and a 1-cycle glitch propagates to the output.

Source files
------------

// File: rtl/pcileech_perst_ctl.sv
// pcileech_perst_ctl: PERST# synchroniser, glitch filter, PCIe reset stretcher and WAKE# driver.
// Ports: clk, rst (async, active-high), pcie_perst_n_pin, wake_req -> pcie_perst_n_flt, pcie_rst,
//        pcie_wake_n, wake_busy, perst_count[15:0].
// Build option: define PCILEECH_PERST_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES filter.
module pcileech_perst_ctl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned RST_HOLD_CYCLES   = 100,
  parameter int unsigned WAKE_PULSE_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcie_perst_n_pin,
  input  logic        wake_req,
  output logic        pcie_perst_n_flt,
  output logic        pcie_rst,
  output logic        pcie_wake_n,
  output logic        wake_busy,
  output logic [15:0] perst_count
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (RST_HOLD_CYCLES < 1 || RST_HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("RST_HOLD_CYCLES out of range");
  end
  if (WAKE_PULSE_CYCLES < 1 || WAKE_PULSE_CYCLES > 65535) begin : g_bad_wake
    $error("WAKE_PULSE_CYCLES out of range");
  end

  localparam logic [15:0] HOLD_MAX = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] WAKE_MAX = 16'(WAKE_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PERST,
    S_HOLD,
    S_RUN,
    S_WAKE
  } state_t;

  state_t      state, state_nx;
  logic [15:0] hold_cnt, hold_nx;
  logic [15:0] wake_cnt, wake_nx;
  logic        sync1;
  logic        s;
  logic        flt_d;
  logic        rise;
  logic        fall;

  // Both stages reset low so PERST# reads as asserted until the pin is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pcie_perst_n_pin;
      s     <= sync1;
    end
  end

`ifdef PCILEECH_PERST_DEBOUNCE_EN
  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt              <= 16'd0;
      pcie_perst_n_flt <= 1'b0;
    end else if (s != pcie_perst_n_flt) begin
      if (cnt == DB_MAX) begin
        pcie_perst_n_flt <= s;
        cnt              <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end else begin
      cnt <= 16'd0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcie_perst_n_flt <= 1'b0;
    end else begin
      pcie_perst_n_flt <= s;
    end
  end
`endif

  // Edge detect on the filtered level; flt_d resets to the same level as
  // the filter so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_d <= 1'b0;
    end else begin
      flt_d <= pcie_perst_n_flt;
    end
  end

  assign rise = pcie_perst_n_flt & ~flt_d;
  assign fall = ~pcie_perst_n_flt & flt_d;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    wake_nx  = wake_cnt;
    unique case (state)
      S_PERST: begin
        if (rise) begin
          state_nx = S_HOLD;
          hold_nx  = HOLD_MAX;
        end else if (wake_req) begin
          state_nx = S_WAKE;
          wake_nx  = WAKE_MAX;
        end
      end
      S_HOLD: begin
        if (fall) begin
          state_nx = S_PERST;
        end else if (hold_cnt == 16'd0) begin
          state_nx = S_RUN;
        end else begin
          hold_nx = hold_cnt - 16'd1;
        end
      end
      S_RUN: begin
        if (fall) begin
          state_nx = S_PERST;
        end
      end
      S_WAKE: begin
        if (rise) begin
          state_nx = S_HOLD;
          hold_nx  = HOLD_MAX;
        end else if (wake_cnt == 16'd0) begin
          state_nx = S_PERST;
        end else begin
          wake_nx = wake_cnt - 16'd1;
        end
      end
      default: state_nx = S_PERST;
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_PERST;
      hold_cnt    <= 16'd0;
      wake_cnt    <= 16'd0;
      pcie_rst    <= 1'b1;
      pcie_wake_n <= 1'b1;
      wake_busy   <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      wake_cnt    <= wake_nx;
      pcie_rst    <= (state_nx != S_RUN);
      pcie_wake_n <= (state_nx != S_WAKE);
      wake_busy   <= (state_nx == S_WAKE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perst_count <= 16'd0;
    end else if (fall && perst_count != 16'hFFFF) begin
      perst_count <= perst_count + 16'd1;
    end
  end

endmodule
